// File: rtl/panel_pkg.sv
// panel_pkg: shared LED colours, colour table and default NPU line codes for the operator panel
package panel_pkg;
  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;
  localparam logic [2:0] COL_OFF       = 3'b000;
  localparam logic [2:0] COL_RED       = 3'(1 << RGB_R);
  localparam logic [2:0] COL_GREEN     = 3'(1 << RGB_G);
  localparam logic [2:0] COL_BLUE      = 3'(1 << RGB_B);
  localparam logic [2:0] COL_CYAN      = COL_GREEN | COL_BLUE;
  localparam logic [2:0] COL_MAGENTA   = COL_RED | COL_BLUE;
  localparam logic [2:0] COL_YELLOW    = COL_RED | COL_GREEN;
  localparam logic [2:0] COL_WHITE     = COL_RED | COL_GREEN | COL_BLUE;
  // no PWM on the panel LEDs, so dim white lights all three channels like white
  localparam logic [2:0] COL_DIM_WHITE = COL_WHITE;
  localparam logic [7:0][2:0] COL_TABLE = {COL_DIM_WHITE, COL_YELLOW, COL_MAGENTA, COL_RED,
                                           COL_CYAN, COL_BLUE, COL_GREEN, COL_WHITE};
  localparam logic [3:0] LINE_NONE      = 4'd0;
  localparam logic [3:0] IMG_C1_LINE    = 4'd1;
  localparam logic [3:0] FLITER_C1_LINE = 4'd2;
  localparam logic [3:0] FLITER_C3_LINE = 4'd3;
  localparam logic [3:0] WEIGHT_C5_LINE = 4'd4;
  localparam logic [19:0] LINE_TABLE_DEF = {WEIGHT_C5_LINE, FLITER_C3_LINE, FLITER_C1_LINE,
                                            IMG_C1_LINE, LINE_NONE};
endpackage

// File: rtl/board_ctrl_panel_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter, debounced level and rise pulse for one button
// ports: clk_i, rst_i (sync, active high), btn_i raw button, lvl_o debounced level,
//        pulse_o one-cycle pulse in the first cycle lvl_o is high after a 0->1 flip
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic lvl_o,
  output logic pulse_o
);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  logic hit;
  assign hit = cnt == CNT_W'(DEBOUNCE_CYC - 1);
  // the flip happens on the DEBOUNCE_CYC-th consecutive cycle that s2 differs from lvl_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      lvl_o   <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      s1      <= btn_i;
      s2      <= s1;
      pulse_o <= 1'b0;
      if (s2 == lvl_o) cnt <= '0;
      else if (hit) begin
        cnt     <= '0;
        lvl_o   <= s2;
        pulse_o <= s2;
      end else cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/board_ctrl_panel.sv
// board_ctrl_panel: operator front panel - button debounce, switch sync, priority mode, wrap selector, RGB LEDs
// ports: clk_i, rst_i (sync, active high), sw_i raw switches, btn_i raw buttons, line_code_i line table,
//        mode_o one-hot mode, btn_lvl_o/btn_pulse_o debounced buttons, sel_idx_o selector index,
//        npu_w_line_o selected line code, sel_step_o index-change pulse, led_o {r,g,b} per mode
module board_ctrl_panel
  import panel_pkg::*;
#(
  parameter int N_SW         = 4,
  parameter int N_BTN        = 4,
  parameter int N_SEL        = 5,
  parameter int SEL_W        = 3,
  parameter int LINE_W       = 4,
  parameter int SEL_MODE     = 0,
  parameter int INC_BTN      = 0,
  parameter int DEC_BTN      = 1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_SW-1:0]         sw_i,
  input  logic [N_BTN-1:0]        btn_i,
  input  logic [N_SEL*LINE_W-1:0] line_code_i,
  output logic [N_SW-1:0]         mode_o,
  output logic [N_BTN-1:0]        btn_lvl_o,
  output logic [N_BTN-1:0]        btn_pulse_o,
  output logic [SEL_W-1:0]        sel_idx_o,
  output logic [LINE_W-1:0]       npu_w_line_o,
  output logic                    sel_step_o,
  output logic [3*N_SW-1:0]       led_o
);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_SEL - 1);
  logic [N_SW-1:0] sw_m, sw_s, mode_nx;
  logic [SEL_W-1:0] idx_nx;
  logic [3*N_SW-1:0] led_nx;
  logic sel_on, inc, dec;
  for (genvar b = 0; b < N_BTN; b++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_i[b]),
      .lvl_o  (btn_lvl_o[b]),
      .pulse_o(btn_pulse_o[b])
    );
  end
  // later iterations overwrite earlier ones, so the highest asserted switch wins
  always_comb begin
    mode_nx = '0;
    for (int k = 0; k < N_SW; k++) if (sw_s[k]) mode_nx = N_SW'(1) << k;
  end
  assign sel_on = mode_o[SEL_MODE];
  assign inc    = btn_pulse_o[INC_BTN] & ~btn_pulse_o[DEC_BTN];
  assign dec    = btn_pulse_o[DEC_BTN] & ~btn_pulse_o[INC_BTN];
  always_comb begin
    idx_nx = !sel_on ? sel_idx_o :
             inc     ? (sel_idx_o == SEL_MAX ? '0 : sel_idx_o + SEL_W'(1)) :
             dec     ? (sel_idx_o == '0 ? SEL_MAX : sel_idx_o - SEL_W'(1)) : sel_idx_o;
  end
  always_comb begin
    led_nx = '0;
    for (int k = 0; k < N_SW; k++)
      led_nx[3*k +: 3] = !mode_o[k] ? COL_OFF : (k == SEL_MODE) ? COL_TABLE[3'(sel_idx_o)] : COL_WHITE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_m         <= '0;
      sw_s         <= '0;
      mode_o       <= '0;
      sel_idx_o    <= '0;
      sel_step_o   <= 1'b0;
      npu_w_line_o <= '0;
      led_o        <= '0;
    end else begin
      sw_m         <= sw_i;
      sw_s         <= sw_m;
      mode_o       <= mode_nx;
      sel_idx_o    <= idx_nx;
      sel_step_o   <= idx_nx != sel_idx_o;
      npu_w_line_o <= sel_on ? line_code_i[sel_idx_o*LINE_W +: LINE_W] : '0;
      led_o        <= led_nx;
    end
  end
endmodule

// File: tb/tb_board_ctrl_panel.sv
// tb_board_ctrl_panel: directed and random checks of board_ctrl_panel against a behavioural model
module tb_board_ctrl_panel;
  localparam int DB = 4;
  localparam int NSEL = 5;
  logic clk = 0, rst;
  logic [3:0] sw, btn;
  logic [19:0] codes_packed = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  logic [3:0] mode_o, btn_lvl_o, btn_pulse_o, npu_w_line_o;
  logic [2:0] sel_idx_o;
  logic sel_step_o;
  logic [11:0] led_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  board_ctrl_panel #(.DEBOUNCE_CYC(DB), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .sw_i(sw), .btn_i(btn), .line_code_i(codes_packed),
    .mode_o(mode_o), .btn_lvl_o(btn_lvl_o), .btn_pulse_o(btn_pulse_o), .sel_idx_o(sel_idx_o),
    .npu_w_line_o(npu_w_line_o), .sel_step_o(sel_step_o), .led_o(led_o)
  );
  logic [2:0] lut [8] = '{3'b111, 3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [3:0] codes [NSEL] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0] s1, s2, b1, b2, m_mode, m_lvl, m_pulse, m_line, nmode, nlvl, npulse;
  logic [11:0] m_led, nled;
  logic m_step;
  int run [4];
  int m_idx, nidx, top;
  always @(posedge clk) begin
    if (rst) begin
      {s1, s2, b1, b2, m_mode, m_lvl, m_pulse, m_line, m_led, m_step} = '0;
      m_idx = 0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      top = -1;
      for (int k = 0; k < 4; k++) if (s2[k]) top = k;
      nmode = top < 0 ? 4'd0 : 4'(1 << top);
      for (int i = 0; i < 4; i++) begin
        nlvl[i] = m_lvl[i];
        npulse[i] = 1'b0;
        if (b2[i] == m_lvl[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == DB) begin
            nlvl[i] = b2[i];
            npulse[i] = b2[i];
            run[i] = 0;
          end
        end
      end
      nidx = m_idx;
      if (m_mode[0] && m_pulse[0] && !m_pulse[1]) nidx = (m_idx + 1) % NSEL;
      if (m_mode[0] && m_pulse[1] && !m_pulse[0]) nidx = (m_idx + NSEL - 1) % NSEL;
      for (int k = 0; k < 4; k++) nled[3*k +: 3] = !m_mode[k] ? 3'b000 : k == 0 ? lut[m_idx % 8] : 3'b111;
      m_step = nidx != m_idx;
      m_line = m_mode[0] ? codes[m_idx] : 4'd0;
      m_led = nled;
      m_idx = nidx;
      m_mode = nmode;
      m_lvl = nlvl;
      m_pulse = npulse;
      s2 = s1; s1 = sw; b2 = b1; b1 = btn;
    end
  end
  wire [31:0] dut_vec = {mode_o, btn_lvl_o, btn_pulse_o, sel_idx_o, npu_w_line_o, sel_step_o, led_o};
  wire [31:0] exp_vec = {m_mode, m_lvl, m_pulse, 3'(m_idx), m_line, m_step, m_led};

  task automatic press(input logic [3:0] m, input int hold);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = 4'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1; sw = 4'b1111; btn = 4'd0;
    repeat (3) @(negedge clk);
    total++; if (dut_vec !== 32'd0) begin bad++; $display("FAIL reset_zero: got %h want 0", dut_vec); end
    rst = 0;
    @(negedge clk);
    total++; if (mode_o !== 4'd0) begin bad++; $display("FAIL mode_lat1: got %b want 0000", mode_o); end
    @(negedge clk);
    total++; if (mode_o !== 4'd0) begin bad++; $display("FAIL mode_lat2: got %b want 0000", mode_o); end
    @(negedge clk);
    total++; if (mode_o !== 4'b1000) begin bad++; $display("FAIL mode_lat3: got %b want 1000", mode_o); end
    @(negedge clk);
    total++; if (led_o !== 12'hE00) begin bad++; $display("FAIL led_mode3: got %h want e00", led_o); end
    total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_glitch_and_press;
    int pulses = 0, steps = 0, c_idx = -1, c_npu = -1;
    sw = 4'b0001;
    repeat (5) @(negedge clk);
    total++; if (mode_o !== 4'b0001 || led_o !== 12'h007) begin bad++; $display("FAIL mode0: got %b/%h want 0001/007", mode_o, led_o); end
    btn = 4'b0001;
    repeat (2) @(negedge clk);
    btn = 4'd0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); pulses += btn_pulse_o[0]; end
    total++; if (pulses != 0 || sel_idx_o !== 3'd0) begin bad++; $display("FAIL glitch: got pulses=%0d idx=%0d want 0/0", pulses, sel_idx_o); end
    btn = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 6) btn = 4'd0;
      pulses += btn_pulse_o[0];
      steps += sel_step_o;
      if (c_idx < 0 && sel_idx_o == 3'd1) c_idx = c;
      if (c_npu < 0 && npu_w_line_o == 4'd1) c_npu = c;
    end
    total++; if (pulses != 1 || steps != 1) begin bad++; $display("FAIL press_once: got pulses=%0d steps=%0d want 1/1", pulses, steps); end
    total++; if (c_idx != 7 || c_npu != 8) begin bad++; $display("FAIL press_timing: got idx@%0d npu@%0d want 7/8", c_idx, c_npu); end
    total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL press_model: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_wrap;
    press(4'b0010, 6);
    total++; if (sel_idx_o !== 3'd0) begin bad++; $display("FAIL dec_to0: got %0d want 0", sel_idx_o); end
    for (int j = 0; j < 5; j++) begin
      press(4'b0001, 6);
      total++; if (sel_idx_o !== 3'((j + 1) % NSEL)) begin bad++; $display("FAIL inc_seq%0d: got %0d want %0d", j, sel_idx_o, (j + 1) % NSEL); end
    end
    press(4'b0010, 6);
    total++; if (sel_idx_o !== 3'd4 || npu_w_line_o !== 4'd4) begin bad++; $display("FAIL dec_wrap: got %0d/%0d want 4/4", sel_idx_o, npu_w_line_o); end
    total++; if (led_o[2:0] !== 3'b100) begin bad++; $display("FAIL led_red: got %b want 100", led_o[2:0]); end
    total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL wrap_model: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_simultaneous;
    int both = 0, steps = 0;
    btn = 4'b0011;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 6) btn = 4'd0;
      both += (btn_pulse_o[1:0] == 2'b11);
      steps += sel_step_o;
    end
    total++; if (both != 1 || steps != 0 || sel_idx_o !== 3'd4) begin bad++; $display("FAIL inc_dec: got both=%0d steps=%0d idx=%0d want 1/0/4", both, steps, sel_idx_o); end
    total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL simul_model: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_other_mode;
    sw = 4'b0010;
    repeat (5) @(negedge clk);
    press(4'b0001, 6);
    total++; if (mode_o !== 4'b0010 || sel_idx_o !== 3'd4 || npu_w_line_o !== 4'd0) begin bad++; $display("FAIL mode1_hold: got %b/%0d/%0d want 0010/4/0", mode_o, sel_idx_o, npu_w_line_o); end
    total++; if (led_o[5:0] !== 6'b111_000) begin bad++; $display("FAIL mode1_led: got %b want 111000", led_o[5:0]); end
    sw = 4'b0001;
    repeat (4) @(negedge clk);
    total++; if (mode_o !== 4'b0001 || npu_w_line_o !== 4'd4) begin bad++; $display("FAIL mode0_restore: got %b/%0d want 0001/4", mode_o, npu_w_line_o); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    press(4'b0010, 6);
    total++; if (sel_idx_o !== 3'd3) begin bad++; $display("FAIL idx3: got %0d want 3", sel_idx_o); end
    btn = 4'b0001;
    repeat (4) @(negedge clk);
    rst = 1; btn = 4'd0;
    @(negedge clk);
    total++; if (dut_vec !== 32'd0) begin bad++; $display("FAIL reset_mid: got %h want 0", dut_vec); end
    rst = 0;
    repeat (5) @(negedge clk);
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    btn = 4'd0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); pulses += btn_pulse_o[0]; end
    total++; if (pulses != 0 || btn_lvl_o[0] !== 1'b0) begin bad++; $display("FAIL short_press: got pulses=%0d lvl=%b want 0/0", pulses, btn_lvl_o[0]); end
    total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL resetmid_model: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_random;
    int hold_left = 0, pick;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL random@%0d: got %h want %h", c, dut_vec, exp_vec); end
      rst = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 59) == 0) begin
        pick = $urandom_range(0, 5);
        sw = pick < 3 ? 4'b0001 : pick == 3 ? 4'b0000 : pick == 4 ? 4'b0010 : 4'($urandom);
      end
      if (hold_left == 0) begin
        btn = $urandom_range(0, 4) == 0 ? 4'($urandom) : {2'b00, 2'($urandom_range(0, 3))};
        hold_left = $urandom_range(1, 9);
      end else hold_left--;
    end
    rst = 0; btn = 4'd0;
  endtask

  initial begin
    test_reset;
    test_glitch_and_press;
    test_wrap;
    test_simultaneous;
    test_other_mode;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_ctrl_panel.md
Name: board_ctrl_panel

Overview:
- Parametrised operator front panel for the FPGA board; successor to the fixed 4-switch/4-button glue logic in the top wrapper.
- Synchronises and debounces buttons, and synchronises switches.
- Resolves a priority one-hot mode from the switches and drives a bidirectional wrap-around selector for the NPU RAM write line.
- Drives per-mode RGB LEDs; its outputs feed data_flow_supervisor mode/select inputs.

Parameters:
- N_SW, 4: switch count = mode count; mode k is driven by sw_i[k].
- N_BTN, 4: button count.
- N_SEL, 5: selector entries; must be ≥ 2 and ≤ 2**SEL_W.
- SEL_W, 3: selector index width.
- LINE_W, 4: width of one NPU write-line code.
- SEL_MODE, 0: mode index in which the selector is active.
- INC_BTN, 0: button that steps the selector up.
- DEC_BTN, 1: button that steps the selector down.
- DEBOUNCE_CYC, 1000000: number of consecutive stable cycles before a debounced level changes (10 ms at 100 MHz).
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYC.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- sw_i  in  N_SW  raw slide switches
- btn_i  in  N_BTN  raw push buttons
- line_code_i  in  N_SEL*LINE_W  line code table; entry i is at bits [i*LINE_W +: LINE_W]
- mode_o  out  N_SW  registered one-hot mode, or all-zero
- btn_lvl_o  out  N_BTN  debounced button levels
- btn_pulse_o  out  N_BTN  one-cycle pulse on each debounced rising edge
- sel_idx_o  out  SEL_W  current selector index
- npu_w_line_o  out  LINE_W  selected line code, or 0
- sel_step_o  out  1  one-cycle pulse whenever sel_idx_o changes
- led_o  out  3*N_SW  RGB per mode channel, {r,g,b} at [3k +: 3]

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge): every output is 0. Reset also clears synchroniser flops, debounce counters and debounced levels. Reset mid-debounce discards the partial count.
- Synchronisers: 2-flop synchroniser on every sw_i and btn_i bit.
- Debounce, per button:
  - The counter clears whenever the synchronised input equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYC-1 the debounced level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYC cycles is rejected.
  - btn_pulse_o[i] is asserted for exactly the cycle after a 0→1 flip. No pulse on release.
- Mode resolution:
  - mode_o is registered; the highest-index asserted synchronised switch wins, as a one-hot vector.
  - No switch asserted → all-zero.
  - Latency: sw_i edge to mode_o = 3 clocks.
- Selector (state = sel_idx_o), updates only while mode_o[SEL_MODE]=1:
  - INC pulse alone: idx+1; N_SEL-1 wraps to 0.
  - DEC pulse alone: idx-1; 0 wraps to N_SEL-1.
  - INC and DEC pulses in the same cycle: no change, no sel_step_o.
  - Outside SEL_MODE, pulses are ignored and the index is held (not cleared).
- npu_w_line_o: registered.
  - Equals line_code_i entry sel_idx_o while mode_o[SEL_MODE]=1, else 0.
  - Entry 0 is the "none" entry by convention.
  - Updates one cycle after sel_idx_o or mode_o changes.
- sel_step_o: high in the cycle sel_idx_o takes its new value.
- LEDs, registered:
  - Channel k ≠ SEL_MODE: white (3'b111) when mode_o[k], else off.
  - Channel SEL_MODE: off when not in SEL_MODE; otherwise the colour from the shared table indexed by sel_idx_o mod 8.
  - Colour table: 0 white, 1 green, 2 blue, 3 cyan, 4 red, 5 magenta, 6 yellow, 7 dim white. The encoding for 7 is fixed in the package.

Decomposition:
- Shared package panel_pkg holds:
  - the LED colour constants and 8-entry colour table;
  - the default line codes: IMG_C1_LINE, FLITER_C1_LINE, FLITER_C3_LINE and WEIGHT_C5_LINE, matching the existing defs header;
  - the RGB bit-order constants.
- One natural sub-module, btn_debounce: synchroniser, counter, level and rise pulse for one button, with DEBOUNCE_CYC and CNT_W as parameters. Instantiate it N_BTN times with generate.
- Mode priority encoder, selector and LED mapping stay inline.

Test Plan (DEBOUNCE_CYC=4, N_SEL=5, codes {0,1,2,3,4}):
- Reset with sw_i=4'b1111, then release → mode_o=4'b1000 exactly 3 clocks after the first sampled edge; led_o channel 3 = 3'b111, all other channels 0.
- sw_i=4'b0001, btn_i[0] glitch of 2 cycles → no btn_pulse_o, sel_idx_o stays 0. Hold btn_i[0] for 6 cycles → one btn_pulse_o[0], sel_idx_o=1, npu_w_line_o=1 one clock later, sel_step_o for one cycle.
- Five INC presses from idx 0 → index sequence 1,2,3,4,0. Then one DEC press → idx 4, npu_w_line_o=4, LED channel 0 = red.
- INC and DEC debounced on the same cycle → idx unchanged, no sel_step_o.
- Switch to sw_i=4'b0010 and press INC → idx held, npu_w_line_o=0, LED channel 0 off. Return to mode 0 → npu_w_line_o restores the held entry.
- Assert rst_i mid-debounce (counter=2) while idx=3 → all outputs 0 on the next clock. After release, a 3-cycle press produces no pulse.
